// File: rtl/ifu_prefetch_queue.sv
// Fetch front end: in-order prefetch with a PC-tagged instruction FIFO and redirect flush; push-to-head latency 1 cycle.
// Requests are credit-gated so responses are never back-pressured; a raised request is held until req_ready.

// Small circular FIFO with synchronous active-low reset and flush; head is read straight from storage.
// One-cycle push-to-head latency; caller guarantees no push when full and no pop when empty.
module pq_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ifu_prefetch_queue #(
    parameter int                ADDR_W          = 64,
    parameter int                INSTR_W         = 32,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'('h80000000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               req_valid,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               req_ready,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_data,
    input  logic               rsp_err,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_err,
    input  logic               instr_ready
);
    localparam int                STRIDE     = INSTR_W / 8;
    localparam int                OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int                CW         = $clog2(DEPTH + 1);
    localparam int                EW         = INSTR_W + 1 + ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRIDE - 1);

    logic              running;
    logic [ADDR_W-1:0] fetch_pc;
    logic              hold_q;
    logic              hold_stale;
    logic [ADDR_W-1:0] hold_addr;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     out_next;
    logic [OW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok;
    logic              acc;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] tag_pc;
    logic [EW-1:0]     head;

    // Live in-flight responses plus buffered entries must fit in the FIFO.
    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                       ((int'(outstanding) - int'(drop_cnt) + int'(fifo_count)) < DEPTH);

    assign req_valid = hold_q | (running & credit_ok);
    assign req_addr  = hold_q ? hold_addr : fetch_pc;
    assign acc       = req_valid & req_ready;
    assign push      = rsp_valid & (drop_cnt == '0) & ~redirect_valid;
    assign pop       = instr_valid & instr_ready & ~redirect_valid;
    assign out_next  = outstanding + OW'(acc) - OW'(rsp_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            running    <= 1'b0;
            fetch_pc   <= RESET_PC;
            hold_q     <= 1'b0;
            hold_stale <= 1'b0;
            hold_addr  <= '0;
            drop_cnt   <= '0;
        end else begin
            running    <= 1'b1;
            hold_q     <= req_valid & ~req_ready;
            hold_stale <= req_valid & ~req_ready & (hold_stale | redirect_valid);
            if (req_valid & ~req_ready) begin
                hold_addr <= req_addr;
            end
            if (redirect_valid) begin
                drop_cnt <= out_next;
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else begin
                // A held request that predates a redirect is already dead when it finally goes out.
                drop_cnt <= drop_cnt + OW'(acc & hold_stale)
                                     - OW'(rsp_valid & (drop_cnt != '0));
                if (acc & ~hold_stale) begin
                    fetch_pc <= fetch_pc + ADDR_W'(STRIDE);
                end
            end
        end
    end

    // Tag FIFO occupancy doubles as the outstanding-request count.
    pq_fifo #(
        .W  (ADDR_W),
        .D  (MAX_OUTSTANDING),
        .CW (OW)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (1'b0),
        .push     (acc),
        .push_dat (req_addr),
        .pop      (rsp_valid),
        .head_dat (tag_pc),
        .count    (outstanding)
    );

    pq_fifo #(
        .W  (EW),
        .D  (DEPTH),
        .CW (CW)
    ) u_instr_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat ({rsp_data, rsp_err, tag_pc}),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = head[EW-1 -: INSTR_W];
    assign instr_err   = head[ADDR_W];
    assign instr_pc    = head[ADDR_W-1:0];
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: in-order bus model with random latency, expected-instruction scoreboard and monitor.
module tb_ifu_prefetch_queue;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_err;
    logic        instr_ready;

    ifu_prefetch_queue #(
        .ADDR_W(64), .INSTR_W(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_err(instr_err),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] ins; logic err; } exp_t;
    typedef struct { logic [63:0] addr; int due; } bus_t;

    exp_t        exp_q[$];
    bus_t        bq[$];
    logic [63:0] acc_log[$];
    logic [63:0] pop_log[$];
    int          cmp_n = 0, fail_n = 0, cyc = 0, last_due = 0, pop_err_n = 0;
    int          err_sel = 0, lat_min = 1, lat_max = 1;
    bit          ready_rand = 0, ready_val = 1, iready_rand = 0, iready_val = 1, rst_val = 0;
    bit          held = 0, stale_allow = 0, want_first = 0;
    logic [63:0] model_pc, req_exp, held_addr, first_pc;

    function automatic logic [31:0] mem_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic bit err_of(input logic [63:0] a);
        logic [31:0] d;
        d = mem_of(a);
        case (err_sel)
            1:       return a == 64'h8000_0004;
            2:       return d[7:5] == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected consumer stream: sequential PCs from the last reset/redirect target.
    task automatic restart_model(input logic [63:0] pc);
        exp_q.delete();
        model_pc = pc;
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc  = model_pc;
            e.ins = mem_of(model_pc);
            e.err = err_of(model_pc);
            exp_q.push_back(e);
            model_pc += 64'd4;
        end
    endtask

    task automatic step(input bit redir, input logic [63:0] rpc);
        bus_t b;
        int   lat;
        @(negedge clk);
        reset          = rst_val;
        redirect_valid = redir;
        redirect_pc    = rpc;
        req_ready      = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
        instr_ready    = iready_rand ? ($urandom_range(0, 2) != 0) : iready_val;
        rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        if (!rst_val) begin
            bq.delete();
            last_due = 0;
        end else if (bq.size() > 0 && bq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_of(bq[0].addr);
            rsp_err   = err_of(bq[0].addr);
            void'(bq.pop_front());
        end
        #1;
        if (!rst_val) begin
            req_exp = RST_PC; stale_allow = 0; held = 0;
            restart_model(RST_PC);
        end else begin
            if (held) begin
                chk("req_hold_valid", 64'(req_valid), 64'd1);
                chk("req_hold_addr", req_addr, held_addr);
            end
            if (req_valid && req_ready) begin
                acc_log.push_back(req_addr);
                if (stale_allow) stale_allow = 0;
                else begin
                    chk("req_addr", req_addr, req_exp);
                    req_exp += 64'd4;
                end
                lat      = $urandom_range(lat_min, lat_max);
                b.addr   = req_addr;
                b.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = b.due;
                bq.push_back(b);
                held = 0;
            end else begin
                held      = req_valid;
                held_addr = req_addr;
            end
            if (redir) begin
                req_exp = rpc & ~64'h3;
                if (req_valid && !req_ready) stale_allow = 1;
                restart_model(rpc & ~64'h3);
            end
        end
        top_up();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic do_reset();
        rst_val = 0;
        step(1'b0, '0);
        acc_log.delete(); pop_log.delete(); pop_err_n = 0;
        step(1'b0, '0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        rst_val = 1;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("first_req_valid", 64'(req_valid), 64'd1);
        chk("first_req_addr", req_addr, RST_PC);
    endtask

    // Monitor: every pop is compared against the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b1) want_first = 0;
            else if (redirect_valid) want_first = 1;
            else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    cmp_n++; fail_n++;
                    $display("FAIL pop_unexpected: got pc %h, expected no pop", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", instr_pc, e.pc);
                    chk("pop_instr", 64'(instr), 64'(e.ins));
                    chk("pop_err", 64'(instr_err), 64'(e.err));
                    pop_log.push_back(instr_pc);
                    pop_err_n += int'(instr_err);
                    if (want_first) begin
                        first_pc   = instr_pc;
                        want_first = 0;
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        int p0;
        int r;
        reset = 0; redirect_valid = 0; redirect_pc = '0; req_ready = 0;
        rsp_valid = 0; rsp_data = '0; rsp_err = 0; instr_ready = 0;

        // Streaming at full rate with 1-cycle bus latency.
        do_reset();
        idle(12);
        chk("t1_req0", at(acc_log, 0), 64'h8000_0000);
        chk("t1_req1", at(acc_log, 1), 64'h8000_0004);
        chk("t1_req2", at(acc_log, 2), 64'h8000_0008);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0);
            cnt += int'(instr_valid);
        end
        chk("t1_no_bubble", 64'(cnt), 64'd10);
        chk("t1_pop0", at(pop_log, 0), 64'h8000_0000);
        chk("t1_pop2", at(pop_log, 2), 64'h8000_0008);

        // Consumer stalled: exactly DEPTH responses buffered, then drained in order.
        iready_val = 0;
        do_reset();
        idle(15);
        chk("t2_acc_cnt", 64'(acc_log.size()), 64'd4);
        chk("t2_req_stop", 64'(req_valid), 64'd0);
        chk("t2_full_valid", 64'(instr_valid), 64'd1);
        iready_val = 1;
        idle(12);
        chk("t2_pop0", at(pop_log, 0), 64'h8000_0000);
        chk("t2_pop3", at(pop_log, 3), 64'h8000_000C);
        chk("t2_resumed", 64'(acc_log.size() > 4), 64'd1);

        // Redirect with two requests in flight.
        lat_min = 2; lat_max = 2;
        do_reset();
        for (int i = 0; i < 10 && bq.size() != 2; i++) step(1'b0, '0);
        chk("t3_two_outstanding", 64'(bq.size()), 64'd2);
        first_pc = '1;
        step(1'b1, 64'h8000_1002);
        step(1'b0, '0);
        chk("t3_flushed", 64'(instr_valid), 64'd0);
        idle(10);
        chk("t3_first_pc", first_pc, 64'h8000_1000);

        // Held request survives a redirect and its response is dropped.
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 20 && acc_log.size() < 4; i++) step(1'b0, '0);
        ready_val = 0;
        idle(3);
        chk("t4_held_valid", 64'(req_valid), 64'd1);
        chk("t4_held_addr", req_addr, 64'h8000_0010);
        first_pc = '1;
        step(1'b1, 64'h2000);
        idle(2);
        chk("t4_still_held", req_addr, 64'h8000_0010);
        ready_val = 1;
        idle(8);
        chk("t4_acc_held", at(acc_log, 4), 64'h8000_0010);
        chk("t4_acc_new", at(acc_log, 5), 64'h2000);
        chk("t4_first_pc", first_pc, 64'h2000);

        // Bus error on the second response only.
        err_sel = 1;
        do_reset();
        idle(12);
        chk("t5_err_cnt", 64'(pop_err_n), 64'd1);
        chk("t5_err_pc", at(pop_log, 1), 64'h8000_0004);

        // Reset in mid-operation with a partially full FIFO.
        err_sel = 0; iready_val = 0; lat_min = 2; lat_max = 2;
        do_reset();
        idle(5);
        chk("t6_busy", 64'(instr_valid), 64'd1);
        do_reset();
        iready_val = 1;
        idle(10);
        chk("t6_restart_pop", at(pop_log, 0), RST_PC);

        // Randomized traffic with redirects, including near address wrap.
        err_sel = 2; lat_min = 1; lat_max = 4; ready_rand = 1; iready_rand = 1;
        do_reset();
        p0 = pop_log.size();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 31);
            if (r == 0) step(1'b1, {$urandom, $urandom});
            else if (r == 1) step(1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
            else step(1'b0, '0);
        end
        ready_rand = 0; iready_rand = 0;
        idle(30);
        chk("rand_progress", 64'(pop_log.size() - p0 > 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
